cnt9999_ctrl: RTL and testbench
===============================

// Module: cnt9999_ctrl
// PURPOSE
//   Run/stop/lap controller for the 4-digit BCD 0..9999 counter chain
//   (four cascaded decade counters with tc-chained ce).
//   - Divides clk into count ticks and drives the chain's ce.
//   - Sequences start/stop, lap-freeze and clear from pulses supplied by
//     the button debouncers.
//   - Owns the display value and overflow handling.
// PARAMETERS
//   PRESCALE  50000  clk cycles per count tick; must be >= 2.
//   SAT_MODE  0      0 = wrap 9999->0000 and set ovf;
//                    1 = stop at 9999 (DONE state).
// PORTS
//   clk       in   1   system clock, rising edge
//   clr       in   1   asynchronous active-high reset
//   btn_ss    in   1   start/stop request, 1-cycle pulse
//   btn_lr    in   1   lap/reset request, 1-cycle pulse
//   cnt_tc    in   1   AND of all four digit tc (chain reads 9999)
//   cnt_q     in   16  chain BCD value {thou,hund,tens,ones}
//   cnt_ce    out  1   count enable to the chain, 1-cycle pulse per tick
//   cnt_clr   out  1   clear pulse to the chain, 1 cycle
//   disp      out  16  BCD value for the display mux
//   running   out  1   1 in RUN or LAP
//   lap       out  1   1 in LAP (display frozen)
//   ovf       out  1   sticky overflow flag
// BEHAVIOUR
//   Reset (clr=1, asynchronous):
//     - state=IDLE, prescaler=0.
//     - cnt_ce=0, cnt_clr=0, disp=16'h0000, running=0, lap=0, ovf=0.
//     - The top level also ties clr to the chain's clr.
//   All outputs are registered.
//   States and transitions (evaluated at every clk edge):
//     IDLE: ss -> RUN; lr ignored.
//     RUN:  ss -> STOP; lr -> LAP, latching cnt_q of that cycle into disp.
//     LAP:  ss -> STOP (disp resumes tracking); lr -> RUN (disp resumes).
//     STOP: ss -> RUN; lr -> IDLE, with cnt_clr=1 for 1 cycle,
//           prescaler=0 and ovf=0.
//     DONE: ss ignored; lr -> IDLE, identical to STOP+lr.
//   ss and lr in the same cycle: ss wins and lr is dropped.
//   Prescaler:
//     - Width is clog2(PRESCALE).
//     - Counts 0..PRESCALE-1 and wraps, only in RUN/LAP.
//     - Holds its value in STOP, so a resume carries the partial period.
//     - Cleared only by reset or on entry to IDLE.
//   Tick:
//     - Tick = prescaler==PRESCALE-1, in RUN/LAP, with no ss this cycle
//       (stop beats tick).
//     - cnt_ce=1 in the cycle after the tick.
//     - First cnt_ce comes PRESCALE cycles after the ss sampled in IDLE.
//     - Successive pulses are exactly PRESCALE cycles apart.
//   Overflow: judged on a tick using the same-cycle cnt_tc.
//     - SAT_MODE=0, tick with cnt_tc=1: cnt_ce issued (chain wraps to
//       0000), ovf<=1 and stays set until reset or STOP/DONE+lr.
//     - SAT_MODE=1, tick with cnt_tc=1: no cnt_ce, state -> DONE, ovf<=1,
//       running<=0.
//   disp:
//     - In IDLE/RUN/STOP/DONE, disp <= cnt_q every cycle (1-cycle lag).
//     - In LAP, disp holds the latched value; ce continues.
//   Flags: running/lap reflect the new state in the cycle after the event.
//   cnt_clr never coincides with cnt_ce.
// TESTING  (PRESCALE=4)
//   1. Reset, then ss pulse: cnt_ce high on cycles +4,+8,+12 after ss;
//      running=1 from +1.
//   2. RUN, ss when prescaler=2: no further cnt_ce. ss again: next cnt_ce
//      2 cycles later, then every 4.
//   3. RUN with cnt_q=16'h0042, lr: disp holds 16'h0042, lap=1, ce keeps
//      pulsing. lr again: disp tracks cnt_q next cycle, lap=0.
//   4. STOP then lr: cnt_clr=1 for exactly 1 cycle, state IDLE, ovf=0.
//      Next ss: first cnt_ce after 4 cycles.
//   5. SAT_MODE=0, cnt_q=16'h9999, cnt_tc=1 at tick: cnt_ce issued, ovf=1
//      and sticky. SAT_MODE=1: no cnt_ce, running=0, ss ignored, lr ->
//      cnt_clr pulse.
//   6. ss+lr same cycle in RUN -> STOP, lap stays 0. clr asserted
//      mid-RUN -> all outputs 0 at once, with no clk edge needed.

Source files
------------

// File: rtl/cnt9999_ctrl_if.sv
// Button, chain and display signals between the run/stop/lap controller
// and its surroundings.
`default_nettype none

interface cnt9999_ctrl_if;
  logic        btn_ss;
  logic        btn_lr;
  logic        cnt_tc;
  logic [15:0] cnt_q;
  logic        cnt_ce;
  logic        cnt_clr;
  logic [15:0] disp;
  logic        running;
  logic        lap;
  logic        ovf;

  modport master (
    output btn_ss, btn_lr, cnt_tc, cnt_q,
    input  cnt_ce, cnt_clr, disp, running, lap, ovf
  );

  modport slave (
    input  btn_ss, btn_lr, cnt_tc, cnt_q,
    output cnt_ce, cnt_clr, disp, running, lap, ovf
  );
endinterface

`default_nettype wire

// File: rtl/cnt9999_ctrl.sv
// Run/stop/lap controller for a 4-digit BCD counter chain: tick prescaler,
// start/stop/lap/clear sequencing, display latch and overflow flag.
`default_nettype none

module cnt9999_ctrl #(
  parameter int PRESCALE = 50000,
  parameter bit SAT_MODE = 1'b0
) (
  input  logic          clk,
  input  logic          clr,
  cnt9999_ctrl_if.slave bus
);

  localparam int            PW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] C_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] C_ONE  = PW'(1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RUN  = 3'd1;
  localparam logic [2:0] S_LAP  = 3'd2;
  localparam logic [2:0] S_STOP = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          ce_q, ce_d;
  logic          cclr_q, cclr_d;
  logic [15:0]   disp_q, disp_d;
  logic          run_q, run_d;
  logic          lap_q, lap_d;
  logic          ovf_q, ovf_d;

  logic w_active, w_lr, w_tick, w_sat, w_clear;

  // ss always wins over lr; a stop request in the tick cycle swallows the tick
  assign w_active = (state_q == S_RUN) || (state_q == S_LAP);
  assign w_lr     = bus.btn_lr & ~bus.btn_ss;
  assign w_tick   = w_active & ~bus.btn_ss & (presc_q == C_LAST);
  assign w_sat    = w_tick & bus.cnt_tc & SAT_MODE;
  assign w_clear  = ((state_q == S_STOP) || (state_q == S_DONE)) & w_lr;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      ce_q    <= 1'b0;
      cclr_q  <= 1'b0;
      disp_q  <= 16'h0000;
      run_q   <= 1'b0;
      lap_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      ce_q    <= ce_d;
      cclr_q  <= cclr_d;
      disp_q  <= disp_d;
      run_q   <= run_d;
      lap_q   <= lap_d;
      ovf_q   <= ovf_d;
    end
  end

  // Saturation takes precedence over a simultaneous lap request
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.btn_ss) state_d = S_RUN;
      S_RUN: begin
        if (w_sat)           state_d = S_DONE;
        else if (bus.btn_ss) state_d = S_STOP;
        else if (w_lr)       state_d = S_LAP;
      end
      S_LAP: begin
        if (w_sat)           state_d = S_DONE;
        else if (bus.btn_ss) state_d = S_STOP;
        else if (w_lr)       state_d = S_RUN;
      end
      S_STOP: begin
        if (bus.btn_ss)      state_d = S_RUN;
        else if (w_lr)       state_d = S_IDLE;
      end
      S_DONE: if (w_lr)      state_d = S_IDLE;
      default:               state_d = S_IDLE;
    endcase
  end

  always_comb begin
    presc_d = presc_q;
    if (w_clear) begin
      presc_d = '0;
    end else if (w_active && !bus.btn_ss) begin
      presc_d = (presc_q == C_LAST) ? '0 : presc_q + C_ONE;
    end

    ce_d   = w_tick & ~w_sat;
    cclr_d = w_clear;
    disp_d = (state_q == S_LAP) ? disp_q : bus.cnt_q;
    run_d  = (state_d == S_RUN) || (state_d == S_LAP);
    lap_d  = (state_d == S_LAP);

    ovf_d = ovf_q;
    if (w_clear) begin
      ovf_d = 1'b0;
    end else if (w_tick && bus.cnt_tc) begin
      ovf_d = 1'b1;
    end
  end

  assign bus.cnt_ce  = ce_q;
  assign bus.cnt_clr = cclr_q;
  assign bus.disp    = disp_q;
  assign bus.running = run_q;
  assign bus.lap     = lap_q;
  assign bus.ovf     = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_cnt9999_ctrl.sv
// Bench for cnt9999_ctrl: wrap and saturating instances share stimulus and
// are checked every cycle against a behavioural model plus directed literals.
`default_nettype none

module tb_cnt9999_ctrl;
  localparam int P = 4;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        ss = 1'b0, lr = 1'b0, tc = 1'b0;
  logic [15:0] q = 16'h0000;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  cnt9999_ctrl_if ifa ();
  cnt9999_ctrl_if ifb ();

  assign ifa.btn_ss = ss;
  assign ifa.btn_lr = lr;
  assign ifa.cnt_tc = tc;
  assign ifa.cnt_q  = q;
  assign ifb.btn_ss = ss;
  assign ifb.btn_lr = lr;
  assign ifb.cnt_tc = tc;
  assign ifb.cnt_q  = q;

  cnt9999_ctrl #(.PRESCALE(P), .SAT_MODE(1'b0)) dut_wrap (.clk(clk), .clr(clr), .bus(ifa));
  cnt9999_ctrl #(.PRESCALE(P), .SAT_MODE(1'b1)) dut_sat  (.clk(clk), .clr(clr), .bus(ifb));

  // ---------------- behavioural model ----------------
  typedef enum int {M_IDLE, M_RUN, M_LAP, M_STOP, M_DONE} mode_t;
  mode_t       mm[2];
  int          left[2];   // counting cycles still needed before the next tick
  bit          e_ce[2], e_clr[2], e_run[2], e_lap[2], e_ovf[2];
  logic [15:0] e_disp[2];

  always @(posedge clk or posedge clr) begin
    for (int m = 0; m < 2; m++) begin
      if (clr) begin
        mm[m] = M_IDLE; left[m] = P;
        e_ce[m] = 0; e_clr[m] = 0; e_run[m] = 0; e_lap[m] = 0; e_ovf[m] = 0;
        e_disp[m] = 16'h0000;
      end else begin
        bit counting, tick, sat, lr_ok;
        lr_ok    = lr && !ss;
        counting = (mm[m] == M_RUN || mm[m] == M_LAP);
        tick     = counting && !ss && left[m] == 1;
        sat      = tick && tc && (m == 1);
        if (mm[m] != M_LAP) e_disp[m] = q;
        e_ce[m]  = tick && !sat;
        e_clr[m] = (mm[m] == M_STOP || mm[m] == M_DONE) && lr_ok;
        if (e_clr[m]) e_ovf[m] = 0;
        else if (tick && tc) e_ovf[m] = 1;
        if (counting && !ss) left[m] = (left[m] == 1) ? P : left[m] - 1;
        if (e_clr[m]) left[m] = P;
        case (mm[m])
          M_IDLE: if (ss) mm[m] = M_RUN;
          M_RUN:  if (sat) mm[m] = M_DONE; else if (ss) mm[m] = M_STOP; else if (lr_ok) mm[m] = M_LAP;
          M_LAP:  if (sat) mm[m] = M_DONE; else if (ss) mm[m] = M_STOP; else if (lr_ok) mm[m] = M_RUN;
          M_STOP: if (ss) mm[m] = M_RUN; else if (lr_ok) mm[m] = M_IDLE;
          default: if (lr_ok) mm[m] = M_IDLE;
        endcase
        e_run[m] = (mm[m] == M_RUN || mm[m] == M_LAP);
        e_lap[m] = (mm[m] == M_LAP);
      end
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!clr) begin
      chk("wrap.ce",   ifa.cnt_ce,  e_ce[0]);
      chk("wrap.clr",  ifa.cnt_clr, e_clr[0]);
      chk("wrap.disp", ifa.disp,    e_disp[0]);
      chk("wrap.run",  ifa.running, e_run[0]);
      chk("wrap.lap",  ifa.lap,     e_lap[0]);
      chk("wrap.ovf",  ifa.ovf,     e_ovf[0]);
      chk("sat.ce",    ifb.cnt_ce,  e_ce[1]);
      chk("sat.clr",   ifb.cnt_clr, e_clr[1]);
      chk("sat.disp",  ifb.disp,    e_disp[1]);
      chk("sat.run",   ifb.running, e_run[1]);
      chk("sat.lap",   ifb.lap,     e_lap[1]);
      chk("sat.ovf",   ifb.ovf,     e_ovf[1]);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    chk("lit.rst_disp", ifa.disp, 16'h0000);
    chk("lit.rst_run", ifa.running, 1'b0);
    chk("lit.rst_ovf", ifa.ovf, 1'b0);

    // start: ce at +4,+8,+12 cycles after the sampled ss
    ss = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      ss = 1'b0;
      chk("lit.start_ce", ifa.cnt_ce, (k >= 5 && k % 4 == 1) ? 1'b1 : 1'b0);
      if (k == 1) chk("lit.start_run", ifa.running, 1'b1);
    end

    // stop with prescaler at 2, then resume: ce 2 cycles after resume, then every 4
    repeat (2) @(negedge clk);
    ss = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      ss = 1'b0;
      chk("lit.stop_ce", ifa.cnt_ce, 1'b0);
      chk("lit.stop_run", ifa.running, 1'b0);
    end
    ss = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      ss = 1'b0;
      chk("lit.resume_ce", ifa.cnt_ce, (k == 3 || k == 7) ? 1'b1 : 1'b0);
    end

    // lap freeze and release
    q = 16'h0042; lr = 1'b1;
    @(negedge clk);
    lr = 1'b0; q = 16'h0100;
    for (int k = 1; k <= 5; k++) begin
      chk("lit.lap_disp", ifa.disp, 16'h0042);
      chk("lit.lap_flag", ifa.lap, 1'b1);
      @(negedge clk);
    end
    lr = 1'b1;
    @(negedge clk);
    lr = 1'b0;
    chk("lit.unlap_flag", ifa.lap, 1'b0);
    @(negedge clk);
    chk("lit.unlap_disp", ifa.disp, 16'h0100);

    // stop then clear
    ss = 1'b1;
    @(negedge clk);
    ss = 1'b0; lr = 1'b1;
    @(negedge clk);
    lr = 1'b0;
    chk("lit.clr_pulse", ifa.cnt_clr, 1'b1);
    @(negedge clk);
    chk("lit.clr_once", ifa.cnt_clr, 1'b0);

    // randomized phase
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      ss = ($urandom_range(0, 11) == 0);
      lr = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 3) == 0) q = 16'h9999;
      else q = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      tc = (q == 16'h9999);
      if ($urandom_range(0, 499) == 0) begin
        #1 clr = 1'b1;
        @(negedge clk);
        #1 clr = 1'b0;
      end
    end

    // ss+lr together, then asynchronous clear mid-run
    @(negedge clk);
    ss = 1'b0; lr = 1'b0; q = 16'h0000; tc = 1'b0;
    #1 clr = 1'b1;
    @(negedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    ss = 1'b1;
    @(negedge clk);
    ss = 1'b0;
    repeat (5) @(negedge clk);
    ss = 1'b1; lr = 1'b1;
    @(negedge clk);
    ss = 1'b0; lr = 1'b0;
    chk("lit.sslr_run", ifa.running, 1'b0);
    chk("lit.sslr_lap", ifa.lap, 1'b0);
    ss = 1'b1;
    @(negedge clk);
    ss = 1'b0;
    q = 16'h0123;
    repeat (2) @(negedge clk);
    chk("lit.pre_async_run", ifa.running, 1'b1);
    chk("lit.pre_async_disp", ifa.disp, 16'h0123);
    @(posedge clk);
    #2 clr = 1'b1;
    #1;
    chk("lit.async_ce", ifa.cnt_ce, 1'b0);
    chk("lit.async_clr", ifa.cnt_clr, 1'b0);
    chk("lit.async_disp", ifa.disp, 16'h0000);
    chk("lit.async_run", ifa.running, 1'b0);
    chk("lit.async_lap", ifa.lap, 1'b0);
    chk("lit.async_ovf", ifa.ovf, 1'b0);
    chk("lit.async_sat_run", ifb.running, 1'b0);
    @(negedge clk);
    #1 clr = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
